// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared types and constants for the Ethernet/IPv4 receive path
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t      byte_array_t[];

    localparam logic [3:0]  IPV4_VERSION     = 4'd4;
    localparam logic [3:0]  IP_MIN_IHL       = 4'd5;
    localparam logic [15:0] IP_HDR_MIN_BYTES = 16'd20;

    // Receive-side parser states
    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        OPTIONS = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } ip_state_t;

endpackage : eth_pkg
`default_nettype wire

// File: rtl/ip_checksum.sv
`default_nettype none
// ============================================================================
//  Module      : ip_checksum
//  Description : 16-bit one's-complement accumulator for the IPv4 header.
//                ok reflects the running sum including the word presented
//                this cycle, so the verdict is available on the last word.
//  Revision    : 1.0 - initial release
// ============================================================================
module ip_checksum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        word_valid,
    input  logic [15:0] word,
    output logic        ok
);

    logic [15:0] r_sum;
    logic [16:0] w_sum17;
    logic [15:0] w_next;

    // A single end-around fold suffices: two 16-bit values never re-carry.
    assign w_sum17 = {1'b0, r_sum} + {1'b0, word};
    assign w_next  = w_sum17[15:0] + {15'd0, w_sum17[16]};
    assign ok      = ((word_valid ? w_next : r_sum) == 16'hFFFF);

    // Running sum, cleared at every frame boundary and once the header ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= 16'h0000;
        end else if (clear) begin
            r_sum <= 16'h0000;
        end else if (word_valid) begin
            r_sum <= w_next;
        end
    end

endmodule : ip_checksum
`default_nettype wire

// File: rtl/ip_parser.sv
`default_nettype none
// ============================================================================
//  Module      : ip_parser
//  Description : IPv4 receive parser. Validates the header (version, IHL,
//                length, protocol, destination, checksum), skips options,
//                forwards the payload with Ethernet padding stripped and
//                reports each frame with exactly one ip_eof or ip_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module ip_parser
    import eth_pkg::*;
#(
    parameter logic [7:0]  TRANSPORT_PROTOCOL = 8'd17,
    parameter logic [31:0] IP_ADDRESS         = 32'hC0A80101
) (
    input  logic  clk,
    input  logic  rst_n,
    input  byte_t eth_data_in,
    input  logic  eth_byte_valid,
    input  logic  eth_eof,
    input  logic  eth_err,
    output byte_t ip_data_out,
    output logic  ip_byte_valid,
    output logic  ip_eof,
    output logic  ip_err
);

    ip_state_t   r_state;
    logic [15:0] r_cnt;      // index of the current byte within the frame
    logic [15:0] r_tlen;
    logic [3:0]  r_ver;
    logic [3:0]  r_ihl;
    logic [7:0]  r_proto;
    logic [7:0]  r_hi;       // high byte of the header word being assembled
    logic [31:0] r_dst;

    logic [5:0]  w_hlen;
    logic        w_in_hdr;
    logic        w_hdr_last;
    logic        w_word_valid;
    logic        w_ck_clear;
    logic        w_ck_ok;
    logic [31:0] w_dst;
    logic        w_hdr_ok;
    logic [16:0] w_rcvd;
    logic        w_len_done;
    logic        w_fwd;

    assign w_hlen   = {r_ihl, 2'b00};
    assign w_in_hdr = (r_state == HEADER) || (r_state == OPTIONS);

    // Header ends at byte 19 unless options follow (a short IHL is rejected there too)
    assign w_hdr_last = ((r_state == HEADER) && (r_cnt == IP_HDR_MIN_BYTES - 16'd1)
                         && (r_ihl <= IP_MIN_IHL))
                     || ((r_state == OPTIONS) && (r_cnt == {10'd0, w_hlen} - 16'd1));

    assign w_word_valid = eth_byte_valid && w_in_hdr && !eth_err && r_cnt[0];
    assign w_ck_clear   = eth_byte_valid && (eth_eof || eth_err || w_hdr_last);

    // Destination's last byte is still on the input when validating at byte 19
    assign w_dst = (r_state == HEADER) ? {r_dst[23:0], eth_data_in} : r_dst;

    assign w_hdr_ok = (r_ver == IPV4_VERSION)
                   && (r_ihl >= IP_MIN_IHL)
                   && (r_tlen >= {10'd0, w_hlen})
                   && (r_proto == TRANSPORT_PROTOCOL)
                   && (w_dst == IP_ADDRESS)
                   && w_ck_ok;

    // Bytes received including the current one, versus the IP total length
    assign w_rcvd     = {1'b0, r_cnt} + 17'd1;
    assign w_len_done = (w_rcvd >= {1'b0, r_tlen});
    assign w_fwd      = (r_cnt < r_tlen);

    ip_checksum u_checksum (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_ck_clear),
        .word_valid (w_word_valid),
        .word       ({r_hi, eth_data_in}),
        .ok         (w_ck_ok)
    );

    // Frame FSM: header capture, validation, payload forwarding, registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HEADER;
            r_cnt         <= 16'd0;
            r_tlen        <= 16'd0;
            r_ver         <= 4'd0;
            r_ihl         <= 4'd0;
            r_proto       <= 8'd0;
            r_hi          <= 8'd0;
            r_dst         <= 32'd0;
            ip_data_out   <= 8'h00;
            ip_byte_valid <= 1'b0;
            ip_eof        <= 1'b0;
            ip_err        <= 1'b0;
        end else begin
            ip_byte_valid <= 1'b0;
            ip_eof        <= 1'b0;
            ip_err        <= 1'b0;

            if (eth_byte_valid) begin
                if (r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 16'd1;
                end

                case (r_state)
                    HEADER, OPTIONS: begin
                        if (r_state == HEADER) begin
                            case (r_cnt)
                                16'd0: begin
                                    r_ver <= eth_data_in[7:4];
                                    r_ihl <= eth_data_in[3:0];
                                end
                                16'd2:  r_tlen[15:8] <= eth_data_in;
                                16'd3:  r_tlen[7:0]  <= eth_data_in;
                                16'd9:  r_proto      <= eth_data_in;
                                16'd16, 16'd17, 16'd18, 16'd19:
                                        r_dst <= {r_dst[23:0], eth_data_in};
                                default: ;
                            endcase
                        end
                        if (!r_cnt[0]) begin
                            r_hi <= eth_data_in;
                        end

                        if (eth_err) begin
                            ip_err  <= 1'b1;
                            r_state <= HEADER;
                            r_cnt   <= 16'd0;
                        end else if (w_hdr_last) begin
                            if (!w_hdr_ok) begin
                                ip_err <= 1'b1;
                                if (eth_eof) begin
                                    r_state <= HEADER;
                                    r_cnt   <= 16'd0;
                                end else begin
                                    r_state <= DROP;
                                end
                            end else if (eth_eof) begin
                                // Header-only frame closing on its last header byte
                                if (w_len_done) begin
                                    ip_eof <= 1'b1;
                                end else begin
                                    ip_err <= 1'b1;
                                end
                                r_state <= HEADER;
                                r_cnt   <= 16'd0;
                            end else begin
                                r_state <= PAYLOAD;
                            end
                        end else if (eth_eof) begin
                            ip_err  <= 1'b1;
                            r_state <= HEADER;
                            r_cnt   <= 16'd0;
                        end else if ((r_state == HEADER)
                                     && (r_cnt == IP_HDR_MIN_BYTES - 16'd1)) begin
                            r_state <= OPTIONS;
                        end
                    end

                    PAYLOAD: begin
                        if (eth_err) begin
                            ip_err  <= 1'b1;
                            r_state <= HEADER;
                            r_cnt   <= 16'd0;
                        end else begin
                            if (w_fwd) begin
                                ip_data_out   <= eth_data_in;
                                ip_byte_valid <= 1'b1;
                            end
                            if (eth_eof) begin
                                if (w_len_done) begin
                                    ip_eof <= 1'b1;
                                end else begin
                                    ip_err <= 1'b1;
                                end
                                r_state <= HEADER;
                                r_cnt   <= 16'd0;
                            end
                        end
                    end

                    DROP: begin
                        if (eth_eof || eth_err) begin
                            r_state <= HEADER;
                            r_cnt   <= 16'd0;
                        end
                    end

                    default: begin
                        r_state <= HEADER;
                        r_cnt   <= 16'd0;
                    end
                endcase
            end
        end
    end

endmodule : ip_parser
`default_nettype wire

// File: tb/tb_ip_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ip_parser
//  Description : Directed self-checking bench for ip_parser
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ip_parser;
    import eth_pkg::*;

    localparam logic [31:0] C_LOCAL_IP = 32'hC0A80101;

    logic  clk = 1'b0;
    logic  rst_n;
    byte_t eth_data_in;
    logic  eth_byte_valid;
    logic  eth_eof;
    logic  eth_err;
    byte_t ip_data_out;
    logic  ip_byte_valid;
    logic  ip_eof;
    logic  ip_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ip_parser dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .eth_data_in    (eth_data_in),
        .eth_byte_valid (eth_byte_valid),
        .eth_eof        (eth_eof),
        .eth_err        (eth_err),
        .ip_data_out    (ip_data_out),
        .ip_byte_valid  (ip_byte_valid),
        .ip_eof         (ip_eof),
        .ip_err         (ip_err)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output recorder
    byte_t       out_q[$];
    int          eof_cnt, err_cnt, both_cnt;
    int unsigned eof_cyc, err_cyc;
    logic        eof_with_byte;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ip_byte_valid) out_q.push_back(ip_data_out);
            if (ip_eof) begin
                eof_cnt++;
                eof_cyc       = cyc;
                eof_with_byte = ip_byte_valid;
            end
            if (ip_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (ip_eof && ip_err) both_cnt++;
        end
    end

    byte_t       frame[0:127];
    int          frame_len;
    int          hdr_len;
    int unsigned c_close, c_hdr_last;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        out_q.delete();
        eof_cnt = 0; err_cnt = 0; both_cnt = 0;
        eof_cyc = 0; err_cyc = 0; eof_with_byte = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            eth_byte_valid = 1'b0;
            eth_eof        = 1'b0;
            eth_err        = 1'b0;
        end
    endtask

    task automatic build(input logic [3:0] ver, input logic [3:0] ihl,
                         input logic [15:0] tlen, input logic [7:0] proto,
                         input logic [31:0] dst, input int npay, input int npad);
        int unsigned s;
        logic [15:0] ck;
        hdr_len   = int'(ihl) * 4;
        frame_len = hdr_len + npay + npad;
        for (int i = 0; i < 128; i++) frame[i] = byte_t'($urandom);
        frame[0]  = {ver, ihl};
        frame[1]  = 8'h00;
        frame[2]  = tlen[15:8];
        frame[3]  = tlen[7:0];
        frame[4]  = 8'h00; frame[5] = 8'h01; frame[6] = 8'h40; frame[7] = 8'h00;
        frame[8]  = 8'h40;
        frame[9]  = proto;
        frame[10] = 8'h00; frame[11] = 8'h00;
        frame[12] = 8'h12; frame[13] = 8'h34; frame[14] = 8'h12; frame[15] = 8'h34;
        frame[16] = dst[31:24]; frame[17] = dst[23:16];
        frame[18] = dst[15:8];  frame[19] = dst[7:0];
        for (int i = hdr_len + npay; i < frame_len; i++) frame[i] = 8'h00;
        s = 0;
        for (int i = 0; i < hdr_len; i += 2) s += {16'd0, frame[i], frame[i+1]};
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        ck = ~s[15:0];
        frame[10] = ck[15:8];
        frame[11] = ck[7:0];
    endtask

    task automatic send_frame(input int gap, input bit err_last, input int n_send);
        for (int i = 0; i < n_send; i++) begin
            idle(gap);
            @(negedge clk);
            eth_byte_valid = 1'b1;
            eth_data_in    = frame[i];
            eth_eof        = (i == frame_len - 1);
            eth_err        = err_last && (i == frame_len - 1);
            if (i == hdr_len - 1)   c_hdr_last = cyc;
            if (i == frame_len - 1) c_close    = cyc;
        end
        idle(4);
    endtask

    function automatic int mismatches();
        int m = 0;
        for (int i = 0; i < out_q.size(); i++)
            if (out_q[i] !== frame[hdr_len + i]) m++;
        return m;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string t;
        int    gap;
        rst_n = 1'b0;
        eth_data_in = 8'h00; eth_byte_valid = 1'b0; eth_eof = 1'b0; eth_err = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check("reset ip_data_out",   int'(ip_data_out), 0);
        check("reset ip_byte_valid", int'(ip_byte_valid), 0);
        check("reset ip_eof",        int'(ip_eof), 0);
        check("reset ip_err",        int'(ip_err), 0);
        rst_n = 1'b1;
        idle(2);

        for (int g = 0; g < 2; g++) begin
            gap = (g == 0) ? 0 : 3;

            // Valid 20-byte payload
            t = $sformatf("g%0d valid", gap);
            clear_mon();
            build(4'd4, 4'd5, 16'd40, 8'd17, C_LOCAL_IP, 20, 0);
            send_frame(gap, 1'b0, frame_len);
            check({t, " bytes"},     out_q.size(), 20);
            check({t, " data"},      mismatches(), 0);
            check({t, " eof"},       eof_cnt, 1);
            check({t, " err"},       err_cnt, 0);
            check({t, " eof time"},  int'(eof_cyc), int'(c_close + 1));
            check({t, " eof+byte"},  int'(eof_with_byte), 1);
            check({t, " hold"},      int'(ip_data_out), int'(frame[39]));

            // Version 3
            t = $sformatf("g%0d ver3", gap);
            clear_mon();
            build(4'd3, 4'd5, 16'd75, 8'd17, C_LOCAL_IP, 55, 0);
            send_frame(gap, 1'b0, frame_len);
            check({t, " err"},      err_cnt, 1);
            check({t, " err time"}, int'(err_cyc), int'(c_hdr_last + 1));
            check({t, " bytes"},    out_q.size(), 0);
            check({t, " eof"},      eof_cnt, 0);

            // Bad checksum
            t = $sformatf("g%0d badck", gap);
            clear_mon();
            build(4'd4, 4'd5, 16'd75, 8'd17, C_LOCAL_IP, 55, 0);
            frame[10] = ~frame[10];
            send_frame(gap, 1'b0, frame_len);
            check({t, " err"},   err_cnt, 1);
            check({t, " bytes"}, out_q.size(), 0);
            check({t, " eof"},   eof_cnt, 0);

            // eth_err on the closing beat
            t = $sformatf("g%0d etherr", gap);
            clear_mon();
            build(4'd4, 4'd5, 16'd75, 8'd17, C_LOCAL_IP, 55, 0);
            send_frame(gap, 1'b1, frame_len);
            check({t, " bytes"},    out_q.size(), 54);
            check({t, " data"},     mismatches(), 0);
            check({t, " err"},      err_cnt, 1);
            check({t, " err time"}, int'(err_cyc), int'(c_close + 1));
            check({t, " eof"},      eof_cnt, 0);

            // Wrong destination
            t = $sformatf("g%0d dst", gap);
            clear_mon();
            build(4'd4, 4'd5, 16'd75, 8'd17, 32'hC0A80102, 55, 0);
            send_frame(gap, 1'b0, frame_len);
            check({t, " err"},   err_cnt, 1);
            check({t, " bytes"}, out_q.size(), 0);

            // Wrong protocol
            t = $sformatf("g%0d proto", gap);
            clear_mon();
            build(4'd4, 4'd5, 16'd75, 8'd6, C_LOCAL_IP, 55, 0);
            send_frame(gap, 1'b0, frame_len);
            check({t, " err"},   err_cnt, 1);
            check({t, " bytes"}, out_q.size(), 0);

            // Ethernet padding stripped
            t = $sformatf("g%0d pad", gap);
            clear_mon();
            build(4'd4, 4'd5, 16'd40, 8'd17, C_LOCAL_IP, 20, 6);
            send_frame(gap, 1'b0, frame_len);
            check({t, " bytes"},    out_q.size(), 20);
            check({t, " data"},     mismatches(), 0);
            check({t, " eof"},      eof_cnt, 1);
            check({t, " err"},      err_cnt, 0);
            check({t, " eof time"}, int'(eof_cyc), int'(c_close + 1));
            check({t, " eof+byte"}, int'(eof_with_byte), 0);

            // IHL 6: four option bytes skipped
            t = $sformatf("g%0d opts", gap);
            clear_mon();
            build(4'd4, 4'd6, 16'd32, 8'd17, C_LOCAL_IP, 8, 0);
            send_frame(gap, 1'b0, frame_len);
            check({t, " bytes"}, out_q.size(), 8);
            check({t, " data"},  mismatches(), 0);
            check({t, " eof"},   eof_cnt, 1);
            check({t, " err"},   err_cnt, 0);

            // Frame shorter than total_length
            t = $sformatf("g%0d short", gap);
            clear_mon();
            build(4'd4, 4'd5, 16'd60, 8'd17, C_LOCAL_IP, 20, 0);
            send_frame(gap, 1'b0, frame_len);
            check({t, " err"},   err_cnt, 1);
            check({t, " eof"},   eof_cnt, 0);
            check({t, " bytes"}, out_q.size(), 20);
            check({t, " both"},  both_cnt, 0);
        end

        // Reset mid-frame, then a clean frame
        clear_mon();
        build(4'd4, 4'd5, 16'd40, 8'd17, C_LOCAL_IP, 20, 0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            eth_byte_valid = 1'b1; eth_data_in = frame[i];
            eth_eof = 1'b0; eth_err = 1'b0;
        end
        @(negedge clk);
        eth_byte_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst ip_byte_valid", int'(ip_byte_valid), 0);
        check("midrst ip_data_out",   int'(ip_data_out), 0);
        rst_n = 1'b1;
        clear_mon();
        build(4'd4, 4'd5, 16'd40, 8'd17, C_LOCAL_IP, 20, 0);
        send_frame(0, 1'b0, frame_len);
        check("midrst bytes", out_q.size(), 20);
        check("midrst data",  mismatches(), 0);
        check("midrst eof",   eof_cnt, 1);
        check("midrst err",   err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_ip_parser
`default_nettype wire
